xbus_fifo: RTL and testbench

Word FIFO chip that buffers XBus transfers between two MC9999 controllers in a design. It sits downstream of a producing controller's XBus port and upstream of a consuming controller's XBus port. Each side uses the same six-signal XBus port bundle as the MC9999, so a producer and a consumer wire directly to it. The producer can burst up to DEPTH words without stalling on the consumer.

---
 rtl/xbus_fifo.sv | 114 +++++++++++
 tb/tb_xbus_fifo.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/xbus_fifo.sv
// xbus_fifo: word FIFO between an XBus producer (x0 side) and an XBus
// consumer (x1 side). Ready/valid outputs and the head word depend only on
// registered state, so there is no input-to-output combinational path.
// Optional feature macro: XBUS_FIFO_LEVEL_EN adds a fill-level register
// sampled on each posedge_big_clk strobe; without it level_out is tied 0.
module xbus_fifo #(
    parameter int DEPTH = 14,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             posedge_big_clk,
    input  logic [WIDTH-1:0] x0_in,
    input  logic             x0_write_in,
    input  logic             x0_read_in,
    output logic [WIDTH-1:0] x0_out,
    output logic             x0_write_out,
    output logic             x0_read_out,
    input  logic [WIDTH-1:0] x1_in,
    input  logic             x1_write_in,
    input  logic             x1_read_in,
    output logic [WIDTH-1:0] x1_out,
    output logic             x1_write_out,
    output logic             x1_read_out,
    output logic [WIDTH-1:0] level_out
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full, empty, push, pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);

    // Readiness comes from registered state only, so a pop on a full cycle
    // does not open a slot for a push in that same cycle.
    assign push = x0_write_in && !full;
    assign pop  = x1_read_in && !empty;

    assign x0_read_out  = !full;
    assign x1_write_out = !empty;
    assign x1_out       = empty ? '0 : mem_q[rp_q];

    assign x0_out       = '0;
    assign x0_write_out = 1'b0;
    assign x1_read_out  = 1'b0;

    // Next-state for pointers and occupancy.
    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (push) wp_d = ptr_inc(wp_q);
        if (pop)  rp_d = ptr_inc(rp_q);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state; reset discards everything buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= x0_in;
    end

`ifdef XBUS_FIFO_LEVEL_EN
    logic [WIDTH-1:0] level_q, level_d;

    // Level snapshot taken once per big-clock step, held in between.
    always_comb begin
        level_d = level_q;
        if (posedge_big_clk) level_d = WIDTH'(cnt_q);
    end

    // Level register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) level_q <= '0;
        else        level_q <= level_d;
    end

    assign level_out = level_q;

    logic unused_inputs;
    assign unused_inputs = ^{x0_read_in, x1_in, x1_write_in};
`else
    assign level_out = '0;

    logic unused_inputs;
    assign unused_inputs = ^{x0_read_in, x1_in, x1_write_in, posedge_big_clk};
`endif

endmodule

// File: tb/tb_xbus_fifo.sv
// Directed bench for xbus_fifo with a queue scoreboard of expected words.
module tb_xbus_fifo;
    localparam int DEPTH = 14;
    localparam int W     = 11;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         posedge_big_clk;
    logic [W-1:0] x0_in, x1_in;
    logic         x0_write_in, x0_read_in, x1_write_in, x1_read_in;
    logic [W-1:0] x0_out, x1_out, level_out;
    logic         x0_write_out, x0_read_out, x1_write_out, x1_read_out;

    xbus_fifo #(.DEPTH(DEPTH), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .posedge_big_clk(posedge_big_clk),
        .x0_in(x0_in), .x0_write_in(x0_write_in), .x0_read_in(x0_read_in),
        .x0_out(x0_out), .x0_write_out(x0_write_out), .x0_read_out(x0_read_out),
        .x1_in(x1_in), .x1_write_in(x1_write_in), .x1_read_in(x1_read_in),
        .x1_out(x1_out), .x1_write_out(x1_write_out), .x1_read_out(x1_read_out),
        .level_out(level_out)
    );

    always #5 clk = ~clk;

    logic [W-1:0] sb[$];
    logic [W-1:0] exp_level;
    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check against model, advance model at posedge.
    task automatic cycle(input logic wr, input logic [W-1:0] d, input logic rd, input logic strobe);
        logic do_push, do_pop;
        int   pre;
        x0_write_in = wr; x0_in = d; x1_read_in = rd; posedge_big_clk = strobe;
        x0_read_in = 1'($urandom); x1_write_in = 1'($urandom); x1_in = W'($urandom);
        #1;
        pre     = sb.size();
        do_push = wr && (pre < DEPTH);
        do_pop  = rd && (pre > 0);
        chk("ready",   {15'd0, x0_read_out},  {15'd0, pre < DEPTH});
        chk("valid",   {15'd0, x1_write_out}, {15'd0, pre > 0});
        chk("head",    {5'd0, x1_out},        (pre > 0) ? {5'd0, sb[0]} : 16'd0);
        chk("level",   {5'd0, level_out},     {5'd0, exp_level});
        chk("tied0",   {1'b0, x0_out, x0_write_out, x1_read_out, 2'b0}, 16'd0);
        @(posedge clk);
        if (do_pop)  void'(sb.pop_front());
        if (do_push) sb.push_back(d);
`ifdef XBUS_FIFO_LEVEL_EN
        if (strobe) exp_level = W'(pre);
`endif
        @(negedge clk);
    endtask

    initial begin
        int k, npop, idx, nexp;
        exp_level = '0;
        rst_n = 1'b0;
        x0_write_in = 0; x1_read_in = 0; posedge_big_clk = 0;
        x0_read_in = 0; x1_write_in = 0; x0_in = '0; x1_in = '0;

        // Reset with random inputs.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            x0_write_in = 1'($urandom); x1_read_in = 1'($urandom);
            posedge_big_clk = 1'($urandom); x0_in = W'($urandom);
            #1;
            chk("rst_valid", {15'd0, x1_write_out}, 16'd0);
            chk("rst_head",  {5'd0, x1_out}, 16'd0);
            chk("rst_level", {5'd0, level_out}, 16'd0);
        end
        @(negedge clk);
        x0_write_in = 0; x1_read_in = 0; posedge_big_clk = 0;
        rst_n = 1'b1;
        #1;
        chk("rst_ready", {15'd0, x0_read_out}, 16'd1);

        // Order: 5, -999, 999 then drain.
        cycle(1, W'(5), 0, 0);
        cycle(1, W'(-999), 0, 0);
        cycle(1, W'(999), 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0);
        #1;
        chk("drain_empty", {15'd0, x1_write_out}, 16'd0);

        // Full: 14 pushes, refused 15th, refused again during a pop, then accepted.
        for (int i = 0; i < DEPTH; i++) cycle(1, W'(100 + i), 0, 0);
        #1;
        chk("full_ready", {15'd0, x0_read_out}, 16'd0);
        cycle(1, W'(7), 0, 0);
        cycle(1, W'(7), 1, 0);
        cycle(1, W'(7), 0, 0);
        k = 0;
        while (k < 30 && sb.size() > 0) begin
            #1;
            if (k == DEPTH - 1) chk("seven_pos", {5'd0, x1_out}, 16'd7);
            cycle(0, '0, 1, 0);
            k++;
        end
        chk("full_drain", 16'(k), 16'(DEPTH));

        // Simultaneous push/pop at cnt=7.
        for (int i = 0; i < 7; i++) cycle(1, W'(300 + i), 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, W'(400 + i), 1, 0);
        npop = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (x1_write_out) npop++;
            cycle(0, '0, 1, 0);
        end
        chk("simul_cnt", 16'(npop), 16'd7);

        // Wrap: stream 0..39 with random read stalls.
        idx = 0; nexp = 0; k = 0;
        while (k < 600 && (idx < 40 || sb.size() > 0)) begin
            logic rd;
            rd = 1'($urandom);
            #1;
            if (rd && x1_write_out) begin
                chk("wrap_data", {5'd0, x1_out}, 16'(nexp));
                nexp++;
            end
            if (idx < 40 && sb.size() < DEPTH) begin
                cycle(1, W'(idx), rd, 0);
                idx++;
            end else begin
                cycle(0, '0, rd, 0);
            end
            k++;
        end
        chk("wrap_count", 16'(nexp), 16'd40);

        // Level: snapshot only on strobe.
        cycle(0, '0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, W'(50 + i), 0, 0);
        cycle(0, '0, 0, 0);
        cycle(0, '0, 0, 1);
        #1;
`ifdef XBUS_FIFO_LEVEL_EN
        chk("level_load", {5'd0, level_out}, 16'd3);
`else
        chk("level_off", {5'd0, level_out}, 16'd0);
`endif

        // Mid-fill asynchronous reset.
        cycle(1, W'(60), 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {15'd0, x1_write_out}, 16'd0);
        chk("arst_head",  {5'd0, x1_out}, 16'd0);
        chk("arst_level", {5'd0, level_out}, 16'd0);
        sb.delete();
        exp_level = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, W'(11), 0, 0);
        cycle(1, W'(12), 1, 0);
        cycle(0, '0, 1, 0);
        cycle(0, '0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
